// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared timing defaults, frame geometry and FSM encoding for the WS2812 transmitter
package ws2812_pkg;

    localparam int DEF_T0H    = 20;
    localparam int DEF_T1H    = 40;
    localparam int DEF_TBIT   = 63;
    localparam int DEF_TLATCH = 4000;

    localparam int N_LEDS       = 5;
    localparam int BITS_PER_LED = 24;
    localparam int FRAME_BITS   = N_LEDS * BITS_PER_LED;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } state_t;

    // Strip expects green first, then red, then blue
    function automatic logic [23:0] wire_order(input logic [23:0] c);
        return {c[15:8], c[23:16], c[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_tx_5_bit_gen.sv
// ws2812_bit_gen: produces one WS2812 bit waveform (high phase then low phase) per go pulse
module ws2812_bit_gen
    import ws2812_pkg::*;
#(
    parameter int T0H  = DEF_T0H,
    parameter int T1H  = DEF_T1H,
    parameter int TBIT = DEF_TBIT,
    parameter int CW   = 6
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_go,
    input  logic i_bit,
    output logic o_dout,
    output logic o_hi_done,
    output logic o_bit_done
);

    logic          r_act;
    logic          r_dout;
    logic          r_bit;
    logic [CW-1:0] r_cnt;
    logic          w_hi_last;
    logic          w_lo_last;

    assign w_hi_last  = r_cnt == (r_bit ? CW'(T1H - 1) : CW'(T0H - 1));
    assign w_lo_last  = r_cnt == (r_bit ? CW'(TBIT - T1H - 1) : CW'(TBIT - T0H - 1));
    assign o_dout     = r_dout;
    assign o_hi_done  = r_dout && w_hi_last;
    assign o_bit_done = r_act && !r_dout && w_lo_last;

    // High phase while r_dout is set, low phase otherwise; counter restarts at each phase change
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_act  <= 1'b0;
            r_dout <= 1'b0;
            r_bit  <= 1'b0;
            r_cnt  <= '0;
        end else if (i_go) begin
            r_act  <= 1'b1;
            r_dout <= 1'b1;
            r_bit  <= i_bit;
            r_cnt  <= '0;
        end else if (r_act) begin
            if (r_dout) begin
                r_dout <= !w_hi_last;
                r_cnt  <= w_hi_last ? '0 : r_cnt + CW'(1);
            end else begin
                r_act <= !w_lo_last;
                r_cnt <= w_lo_last ? '0 : r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ws2812_tx_5.sv
// ws2812_tx_5: snapshots five colours on start and sends them as one WS2812 frame plus latch gap
module ws2812_tx_5
    import ws2812_pkg::*;
#(
    parameter int T0H    = DEF_T0H,
    parameter int T1H    = DEF_T1H,
    parameter int TBIT   = DEF_TBIT,
    parameter int TLATCH = DEF_TLATCH
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] led0,
    input  logic [23:0] led1,
    input  logic [23:0] led2,
    input  logic [23:0] led3,
    input  logic [23:0] led4,
    output logic        dout,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(TBIT > TLATCH ? TBIT : TLATCH);

    state_t                r_state;
    state_t                w_next;
    logic [FRAME_BITS-1:0] r_sr;
    logic [6:0]            r_bcnt;
    logic [CW-1:0]         r_lcnt;
    logic [CW-1:0]         w_lcnt_next;
    logic                  r_busy;
    logic                  r_done;
    logic [FRAME_BITS-1:0] w_frame;
    logic                  w_accept;
    logic                  w_last_bit;
    logic                  w_latch_end;
    logic                  w_go;
    logic                  w_bit;
    logic                  w_hi_done;
    logic                  w_bit_done;

    assign w_frame = {wire_order(led0), wire_order(led1), wire_order(led2),
                      wire_order(led3), wire_order(led4)};
    assign busy    = r_busy;
    assign done    = r_done;

    ws2812_bit_gen #(
        .T0H (T0H),
        .T1H (T1H),
        .TBIT(TBIT),
        .CW  (CW)
    ) u_bit_gen (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_go      (w_go),
        .i_bit     (w_bit),
        .o_dout    (dout),
        .o_hi_done (w_hi_done),
        .o_bit_done(w_bit_done)
    );

    // Next state, next latch count and the bit handed to the generator
    always_comb begin
        w_accept    = (r_state == IDLE) && start;
        w_last_bit  = r_bcnt == 7'(FRAME_BITS - 1);
        w_latch_end = (r_state == LATCH) && (r_lcnt == CW'(TLATCH - 1));
        w_go        = w_accept || (w_bit_done && !w_last_bit);
        w_bit       = w_accept ? w_frame[FRAME_BITS-1] : r_sr[FRAME_BITS-1];
        w_next      = r_state;
        case (r_state)
            IDLE:    w_next = start ? HIGH : IDLE;
            HIGH:    w_next = w_hi_done ? LOW : HIGH;
            LOW:     w_next = w_bit_done ? (w_last_bit ? LATCH : HIGH) : LOW;
            LATCH:   w_next = w_latch_end ? IDLE : LATCH;
            default: w_next = IDLE;
        endcase
        w_lcnt_next = (r_state == LATCH && w_next == LATCH) ? r_lcnt + CW'(1) : '0;
    end

    // State, counters, shift register and registered status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_bcnt  <= '0;
            r_lcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_lcnt  <= w_lcnt_next;
            r_busy  <= w_next != IDLE;
            r_done  <= (w_next == LATCH) && (w_lcnt_next == CW'(TLATCH - 1));
            if (w_accept) begin
                // The first bit goes straight to the generator, so the register holds what follows it
                r_sr   <= {w_frame[FRAME_BITS-2:0], 1'b0};
                r_bcnt <= '0;
            end else if (w_bit_done) begin
                r_sr   <= {r_sr[FRAME_BITS-2:0], 1'b0};
                r_bcnt <= w_last_bit ? r_bcnt : r_bcnt + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_tx_5.sv
// tb_ws2812_tx_5: randomized and directed frames checked cycle by cycle against a waveform model
module tb_ws2812_tx_5;

    localparam int T0H    = 4;
    localparam int T1H    = 8;
    localparam int TBIT   = 13;
    localparam int TLATCH = 50;
    localparam int NB     = 120;
    localparam int FLEN   = NB * TBIT + TLATCH;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] led [5];
    logic        dout, busy, done;

    int   n_chk = 0, n_pass = 0, cyc = 0, s_edge = 0, n_done = 0, cur = 0, nd0 = 0;
    int   pw[$], rise[$];
    logic prev = 1'b0;
    bit   chk_en = 1'b0;

    bit          m_act = 1'b0;
    int          m_t = 0;
    logic [23:0] m_led [5];

    ws2812_tx_5 #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TLATCH(TLATCH)) dut (
        .clock(clock), .reset(reset), .start(start),
        .led0(led[0]), .led1(led[1]), .led2(led[2]), .led3(led[3]), .led4(led[4]),
        .dout(dout), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Frame bit b: LED b/24, bytes in G,R,B order, each MSB first
    function automatic logic mbit(input int b);
        int p, sh;
        p  = b % 24;
        sh = (p < 8) ? 8 : (p < 16) ? 16 : 0;
        return m_led[b / 24][sh + 7 - p % 8];
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) m_act = 1'b0;
        else if (m_act) begin
            m_t++;
            if (m_t == FLEN) m_act = 1'b0;
        end else if (start) begin
            m_act = 1'b1;
            m_t   = 0;
            for (int k = 0; k < 5; k++) m_led[k] = led[k];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    always @(posedge clock) begin : cmp
        logic ed;
        #1;
        if (chk_en) begin
            ed = m_act && m_t < NB * TBIT && (m_t % TBIT) < (mbit(m_t / TBIT) ? T1H : T0H);
            chk("cycle {dout,busy,done}", int'({dout, busy, done}), int'({ed, m_act, m_act && m_t == FLEN - 1}));
        end
    end

    always @(posedge clock) begin
        #1;
        if (done) n_done++;
        if (dout && !prev) rise.push_back(cyc);
        if (dout) cur++;
        else if (prev) begin
            pw.push_back(cur);
            cur = 0;
        end
        prev = dout;
    end

    task automatic go();
        @(negedge clock);
        pw.delete();
        rise.delete();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        s_edge = cyc;
    endtask

    task automatic wait_done(input string nm, input int exp);
        for (int i = 0; i < FLEN + 20; i++) begin
            @(negedge clock);
            if (done) break;
        end
        chk(nm, cyc - s_edge, exp);
    endtask

    task automatic chk_widths(input string nm, input int lo, input int hi);
        int bad;
        bad = 0;
        chk({nm, " pulse count"}, pw.size(), NB);
        chk({nm, " first rise"}, rise.size() > 0 ? rise[0] : -1, s_edge);
        for (int i = 0; i < NB; i++)
            if (i >= pw.size() || pw[i] != ((i >= lo && i <= hi) ? T1H : T0H)) bad++;
        for (int i = 1; i < rise.size(); i++)
            if (rise[i] - rise[i-1] != TBIT) bad++;
        chk({nm, " bad widths/periods"}, bad, 0);
    endtask

    task automatic clear_leds();
        for (int k = 0; k < 5; k++) led[k] = 24'h0;
    endtask

    initial begin
        clear_leds();
        repeat (3) @(negedge clock);
        chk("reset outputs", int'({dout, busy, done}), 0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // single frame: R=FF on led0 -> bits 8..15 long; done at 120*13+50-1 = 1609
        led[0] = 24'hFF0000;
        go();
        chk("busy at accept edge", int'(busy), 1);
        wait_done("single done offset", 1609);
        chk_widths("single", 8, 15);
        @(negedge clock);
        chk("single busy fall", int'(busy), 0);

        // snapshot: led2 changes mid-frame, only the next frame sees it
        clear_leds();
        go();
        repeat (30 * TBIT) @(negedge clock);
        led[2] = 24'h00FF00;
        wait_done("snap1 done offset", 1609);
        chk_widths("snap1", -1, -2);
        go();
        wait_done("snap2 done offset", 1609);
        chk_widths("snap2", 48, 55);

        // busy lockout: starts at bit 5, bit 119 and with done are all ignored
        for (int k = 0; k < 5; k++) led[k] = 24'($urandom);
        nd0 = n_done;
        go();
        repeat (5 * TBIT) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (119 * TBIT + 3 - (5 * TBIT + 1)) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done("lock done offset", 1609);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (FLEN) @(negedge clock);
        chk("lock done count", n_done - nd0, 1);
        chk("lock idle", int'(busy), 0);

        // reset during bit 60 high phase
        go();
        repeat (60 * TBIT + 1) @(negedge clock);
        chk("bit60 high before reset", int'(dout), 1);
        nd0   = n_done;
        reset = 1'b1;
        #1;
        chk("async reset outputs", int'({dout, busy, done}), 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (FLEN) @(negedge clock);
        chk("no done after abort", n_done - nd0, 0);
        clear_leds();
        led[1] = 24'h0000FF;
        go();
        wait_done("post-reset done offset", 1609);
        chk_widths("post-reset", 40, 47);

        // back-to-back: restart the cycle after done
        clear_leds();
        led[4] = 24'h000001;
        go();
        wait_done("b2b first done offset", 1609);
        go();
        wait_done("b2b second done offset", 1609);
        chk_widths("b2b", 119, 119);

        // randomized traffic: sparse starts and colour changes checked by the model
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 5; k++) led[k] = 24'($urandom);
            go();
            repeat (2 * FLEN) begin
                @(negedge clock);
                start = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 49) == 0) led[$urandom_range(0, 4)] = 24'($urandom);
            end
            start = 1'b0;
            for (int i = 0; i < FLEN + 10 && busy; i++) @(negedge clock);
            chk("random round idle", int'(busy), 0);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ws2812_tx_5.md
# ws2812_tx_5

Serial transmitter for a chain of five WS2812-class addressable LEDs. It is the downstream end of the five-LED colour frame interface: it takes the five 24-bit colours `led0`..`led4` produced by the frame decoder and, on a `start` pulse, snapshots them. It then shifts them out on a single-wire NRZ data line with WS2812 pulse-width timing, followed by the latch (reset) gap. The block sits between the game's LED frame logic and the board pin driving the LED strip.

## Interface
Parameters (cycle counts at the 50 MHz system clock):
- `T0H`, default 20: high time, in cycles, of a `0` bit (0.40 µs).
- `T1H`, default 40: high time, in cycles, of a `1` bit (0.80 µs).
- `TBIT`, default 63: total bit period in cycles (1.26 µs); must satisfy `TBIT > T1H > T0H > 0`.
- `TLATCH`, default 4000: low time in cycles after the last bit (80 µs latch gap).

Ports:
- `clock`, in, 1: system clock. One clock domain only.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: single-cycle request to send one frame; sampled only in IDLE.
- `led0`..`led4`, in, 24 each: colours in {R[23:16], G[15:8], B[7:0]} format; `led0` is nearest the pin.
- `dout`, out, 1: registered serial data to the strip.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`.
- `done`, out, 1: single-cycle pulse when the latch gap completes.

## Operation
- FSM states: IDLE, HIGH, LOW, LATCH.
- IDLE: `dout`=0, `busy`=0.
  - On `start`=1 at a rising edge, the block snapshots all five colours into an internal 120-bit shift register.
  - Each colour is reordered to wire order {G, R, B}. The frame order is `led0` first, and each byte is sent MSB first.
  - Bit counter is set to 0, cycle counter to 0, and the FSM enters HIGH.
- HIGH: `dout`=1 for `T1H` cycles if the current bit is 1, else for `T0H` cycles, then the FSM enters LOW.
- LOW: `dout`=0 for the rest of the bit, so HIGH plus LOW equals exactly `TBIT` cycles.
  - At the end of the bit, the shift register advances.
  - If the bit counter was 119, the FSM enters LATCH; otherwise it increments the counter and enters HIGH.
- LATCH: `dout`=0 for `TLATCH` cycles. On the final cycle the block asserts `done` for one cycle, returns to IDLE, and drops `busy`.
- Input changes: `start` while `busy` is ignored and not queued. Changes on `led0`..`led4` after the snapshot do not affect the frame in flight.
- Counters:
  - Bit counter is 7 bits, range 0..119, with no wrap past 119.
  - Cycle counter width is `$clog2(max(TBIT, TLATCH))` and it resets to 0 at every state change.
- `reset` asserted at any time forces IDLE immediately, with all outputs and registers cleared. A partial frame is abandoned, with no `done` pulse. The strip self-latches on the resulting low period.

## Timing
- Reset values: `dout`=0, `busy`=0, `done`=0. The shift register, counters and state are cleared to zero/IDLE.
- `start` sampled at edge k: at edge k, `dout`=1 and `busy`=1 (first HIGH cycle).
- Frame length: `done` is high during the cycle beginning at edge k + 120·`TBIT` + `TLATCH` − 1, and `busy` falls at the following edge.
- `start` coincident with `done`: ignored, because the FSM is not yet in IDLE. The earliest accepted restart is one cycle after `done`.
- All outputs are registered, so there is no combinational path from inputs to `dout`.

## Structure
- Shared package `ws2812_pkg`:
  - default timing constants `T0H`/`T1H`/`TBIT`/`TLATCH` for 50 MHz;
  - the FSM state encoding;
  - the frame size constants `N_LEDS`=5 and `BITS_PER_LED`=24.
- One sub-module, `ws2812_bit_gen`:
  - takes `bit_in` and `go`;
  - produces `dout` and `bit_done` using the HIGH/LOW timing;
  - the top level owns the shift register, bit counter and LATCH phase.

## Test plan
- Reset check: assert `reset` mid-simulation → `dout`=0, `busy`=0, `done`=0 immediately, without waiting for a clock edge.
- Single frame: `led0`=24'hFF0000, others 0, pulse `start` → bits 0–7 are 20-cycle highs, bits 8–15 are 40-cycle highs, bits 16–119 are 20-cycle highs. Every bit period is 63 cycles. The latch gap is 4000 cycles low. `done` rises at cycle 120·63+4000−1 = 11559 after `start`.
- Snapshot: change `led2` to 24'h00FF00 at bit 30 of a frame that started with all zeros → every bit of that frame is a 20-cycle pulse. The next frame carries the 8 ones at bits 48–55.
- Busy lockout: pulse `start` at bits 5 and 119 and in the same cycle as `done` → exactly one frame is sent, and `done` fires once.
- Reset mid-frame: assert `reset` during bit 60 HIGH → `dout` goes to 0 at once and no `done` pulse occurs. The next `start` after reset produces a full 120-bit frame from bit 0.
- Back-to-back: `start` one cycle after `done`, with `led4`=24'h000001 → the frame is accepted, and only bit 119 is a 40-cycle high.
